// File: rtl/scroll_ctrl.sv
// Auto-scroll controller for an 8-digit HELLO rotation: prescaled step ticks, home dwell, single-step button.
// Optional build macro SCROLL_BOUNCE_EN selects ping-pong 0..7..0 scrolling instead of wrap-around.
module scroll_ctrl #(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       RUN,
  input  logic       DIR,
  input  logic [1:0] SPEED,
  input  logic       STEP_N,
  output logic [2:0] M,
  output logic       TICK,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    st_pause = 2'b00,
    st_run   = 2'b01,
    st_hold  = 2'b10,
    st_bad   = 2'b11
  } state_t;

  localparam logic [23:0] DIV = 24'(TICK_DIV);
  localparam int unsigned HW  = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_t        state, state_d;
  logic [23:0]   cnt, limit;
  logic [1:0]    speed_q;
  logic          speed_chg, tick_i, clr_pre;
  logic [HW-1:0] hcnt, hcnt_d;
  logic          s1, s2, s3, step_fall;
  logic          adv, land_home;
  logic [2:0]    m_next;

  assign STATE     = state;
  assign limit     = (DIV >> SPEED) - 24'd1;
  assign speed_chg = (SPEED != speed_q);
  // A speed change restarts the period, so a stale count never fires a tick.
  assign tick_i    = (cnt == limit) && !speed_chg;
  assign step_fall = s3 && !s2;

`ifdef SCROLL_BOUNCE_EN
  logic up, up_d;

  always_comb begin
    m_next    = up ? 3'(M + 3'd1) : 3'(M - 3'd1);
    land_home = (m_next == 3'd7) || (m_next == 3'd0);
    up_d      = up;
    if (adv && (m_next == 3'd7)) up_d = 1'b0;
    if (adv && (m_next == 3'd0)) up_d = 1'b1;
  end
`else
  always_comb begin
    m_next    = DIR ? 3'(M - 3'd1) : 3'(M + 3'd1);
    land_home = (m_next == 3'd0);
  end
`endif

  always_comb begin
    state_d = state;
    hcnt_d  = hcnt;
    adv     = 1'b0;
    clr_pre = speed_chg;
    case (state)
      st_pause: begin
        clr_pre = 1'b1;
        hcnt_d  = '0;
        // RUN rising wins over a simultaneous step edge.
        if (RUN)            state_d = st_run;
        else if (step_fall) adv     = 1'b1;
      end
      st_run: begin
        if (!RUN) state_d = st_pause;
        else if (tick_i) begin
          adv = 1'b1;
          if (land_home) state_d = st_hold;
        end
      end
      st_hold: begin
        if (!RUN) begin
          state_d = st_pause;
          hcnt_d  = '0;
        end else if (tick_i) begin
          if (hcnt == HOLD_LAST) begin
            state_d = st_run;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt + 1'b1;
          end
        end
      end
      default: state_d = st_pause;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= st_pause;
      M       <= '0;
      TICK    <= 1'b0;
      cnt     <= '0;
      hcnt    <= '0;
      speed_q <= '0;
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
`ifdef SCROLL_BOUNCE_EN
      up      <= 1'b1;
`endif
    end else begin
      state   <= state_d;
      hcnt    <= hcnt_d;
      speed_q <= SPEED;
      s1      <= STEP_N;
      s2      <= s1;
      s3      <= s2;
      cnt     <= (clr_pre || tick_i) ? '0 : cnt + 24'd1;
      TICK    <= adv;
      if (adv) M <= m_next;
`ifdef SCROLL_BOUNCE_EN
      up      <= up_d;
`endif
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed self-checking bench for scroll_ctrl with TICK_DIV=8, HOLD_TICKS=2.
module tb_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, run, dir, step_n;
  logic [1:0] speed;
  logic [2:0] m;
  logic       tick;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  scroll_ctrl #(.TICK_DIV(8), .HOLD_TICKS(2)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .RUN(run), .DIR(dir), .SPEED(speed),
    .STEP_N(step_n), .M(m), .TICK(tick), .STATE(state)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; dir = 1'b0; speed = 2'd0; step_n = 1'b1;
    #2;
    checks++; if (m !== 3'd0)     begin failures++; $display("FAIL reset_m got=%0d exp=0", m); end
    checks++; if (tick !== 1'b0)  begin failures++; $display("FAIL reset_tick got=%0b exp=0", tick); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
  endtask

`ifndef SCROLL_BOUNCE_EN
  task automatic test_run_sequence();
    logic [2:0] em;
    logic       et;
    logic [1:0] es;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      em = (k < 9) ? 3'd0 : (k < 65) ? 3'((k - 1) / 8) : (k < 89) ? 3'd0 : 3'd1;
      et = (k >= 9) && ((k - 1) % 8 == 0) && (k != 73) && (k != 81);
      es = (k < 65) ? 2'd1 : (k < 81) ? 2'd2 : 2'd1;
      checks++; if (m !== em)     begin failures++; $display("FAIL run_m k=%0d got=%0d exp=%0d", k, m, em); end
      checks++; if (tick !== et)  begin failures++; $display("FAIL run_tick k=%0d got=%0b exp=%0b", k, tick, et); end
      checks++; if (state !== es) begin failures++; $display("FAIL run_state k=%0d got=%0d exp=%0d", k, state, es); end
    end
  endtask

  task automatic test_speed();
    logic [2:0] em;
    logic       et;
    speed = 2'd3;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      if (j <= 6) begin
        em = (j == 1) ? 3'd1 : 3'(j);
        et = (j >= 2);
      end else begin
        em = (j < 15) ? 3'd6 : 3'd7;
        et = (j == 15);
      end
      checks++; if (m !== em)    begin failures++; $display("FAIL speed_m j=%0d got=%0d exp=%0d", j, m, em); end
      checks++; if (tick !== et) begin failures++; $display("FAIL speed_tick j=%0d got=%0b exp=%0b", j, tick, et); end
      if (j == 6) speed = 2'd0;
    end
  endtask

  task automatic test_reset_mid_hold();
    repeat (10) @(negedge clk);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL hold_entered got=%0d exp=2", state); end
    checks++; if (m !== 3'd0)     begin failures++; $display("FAIL hold_m got=%0d exp=0", m); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL midreset_state got=%0d exp=0", state); end
    checks++; if (m !== 3'd0)     begin failures++; $display("FAIL midreset_m got=%0d exp=0", m); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL release_state got=%0d exp=1", state); end
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (m !== ((k == 9) ? 3'd1 : 3'd0)) begin
        failures++; $display("FAIL release_m k=%0d got=%0d exp=%0d", k, m, (k == 9) ? 1 : 0);
      end
      checks++;
      if (tick !== (k == 9)) begin
        failures++; $display("FAIL release_tick k=%0d got=%0b exp=%0b", k, tick, (k == 9));
      end
    end
  endtask

  task automatic test_step();
    run = 1'b0; dir = 1'b1; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL step_pause got=%0d exp=0", state); end
    step_n = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (m !== ((k == 3) ? 3'd7 : 3'd0)) begin
        failures++; $display("FAIL step_m k=%0d got=%0d exp=%0d", k, m, (k == 3) ? 7 : 0);
      end
      checks++;
      if (tick !== (k == 3)) begin
        failures++; $display("FAIL step_tick k=%0d got=%0b exp=%0b", k, tick, (k == 3));
      end
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if ((m !== 3'd7) || (tick !== 1'b0)) begin
        failures++; $display("FAIL step_held k=%0d m=%0d tick=%0b exp m=7 tick=0", k, m, tick);
      end
    end
    step_n = 1'b1;
    repeat (4) @(negedge clk);
    dir = 1'b0; step_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m !== 3'd0)     begin failures++; $display("FAIL step_wrap_m got=%0d exp=0", m); end
    checks++; if (tick !== 1'b1)  begin failures++; $display("FAIL step_wrap_tick got=%0b exp=1", tick); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL step_wrap_state got=%0d exp=0", state); end
    @(negedge clk);
    checks++; if (tick !== 1'b0)  begin failures++; $display("FAIL step_tick_once got=%0b exp=0", tick); end
    step_n = 1'b1;
  endtask
`else
  task automatic test_bounce();
    logic [2:0] em;
    logic [1:0] es;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      dir = ~dir;
      if (k < 9)        em = 3'd0;
      else if (k < 57)  em = 3'((k - 1) / 8);
      else if (k < 73)  em = 3'd7;
      else if (k < 129) em = 3'(7 - (k - 73) / 8);
      else if (k < 153) em = 3'd0;
      else              em = 3'd1;
      es = (k < 57) ? 2'd1 : (k < 73) ? 2'd2 : (k < 129) ? 2'd1 : (k < 145) ? 2'd2 : 2'd1;
      checks++; if (m !== em)     begin failures++; $display("FAIL bounce_m k=%0d got=%0d exp=%0d", k, m, em); end
      checks++; if (state !== es) begin failures++; $display("FAIL bounce_state k=%0d got=%0d exp=%0d", k, state, es); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef SCROLL_BOUNCE_EN
    test_run_sequence();
    test_speed();
    test_reset_mid_hold();
    test_step();
`else
    test_bounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
